// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor D = A - B - B_in, LSB first, one bit per cycle
// Optional signed-overflow output V enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic             a_bit, b_bit, diff_bit, br_next;
  logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             v_q, v_d;
`endif

  // Single full-subtractor cell operating on the current LSBs.
  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0];
    diff_bit = a_bit ^ b_bit ^ br_q;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_next = {diff_bit, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    v_d     = v_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = B_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_next;
        br_d  = br_next;
        if (cnt_q == LAST_BIT) begin
          // Publish the result as DONE is entered; counter stays put so it never wraps.
          dout_d  = res_next;
          bout_d  = br_next;
          state_d = S_DONE;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          v_d     = (a_msb_q != b_msb_q) & (res_next[WIDTH-1] != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      v_q     <= v_d;
`endif
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign D     = dout_q;
  assign B_out = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign V     = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         B_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         B_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic         V;
`endif

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .A     (A),
    .B     (B),
    .B_in  (B_in),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .B_out (B_out)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    .V     (V)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a;
    B = b;
    B_in = bin;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges after the accepting edge until done is seen; busy cycles observed meanwhile.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 30) begin
      if (busy) busy_cnt++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", done); end
    checks++; if (D !== 8'h00) begin failures++; $display("FAIL reset_D actual=%h required=00", D); end
    checks++; if (B_out !== 1'b0) begin failures++; $display("FAIL reset_B_out actual=%b required=0", B_out); end
  endtask

  task automatic test_basic();
    int edges, bc;
    do_start(8'd100, 8'd37, 1'b0);
    wait_done(edges, bc);
    checks++; if (edges !== W) begin failures++; $display("FAIL basic_latency actual=%0d required=%0d", edges, W); end
    checks++; if (bc !== W) begin failures++; $display("FAIL basic_busy_cycles actual=%0d required=%0d", bc, W); end
    checks++; if (D !== 8'h3F) begin failures++; $display("FAIL basic_D actual=%h required=3f", D); end
    checks++; if (B_out !== 1'b0) begin failures++; $display("FAIL basic_B_out actual=%b required=0", B_out); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse actual=%b required=0", done); end
    tick();
    tick();
    checks++; if (D !== 8'h3F) begin failures++; $display("FAIL basic_D_hold actual=%h required=3f", D); end
  endtask

  task automatic test_underflow();
    int edges, bc;
    do_start(8'h00, 8'h01, 1'b0);
    wait_done(edges, bc);
    checks++; if (D !== 8'hFF) begin failures++; $display("FAIL underflow_D actual=%h required=ff", D); end
    checks++; if (B_out !== 1'b1) begin failures++; $display("FAIL underflow_B_out actual=%b required=1", B_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    int edges, bc;
    do_start(8'h50, 8'h50, 1'b1);
    wait_done(edges, bc);
    checks++; if (D !== 8'hFF) begin failures++; $display("FAIL b2b_first_D actual=%h required=ff", D); end
    checks++; if (B_out !== 1'b1) begin failures++; $display("FAIL b2b_first_B_out actual=%b required=1", B_out); end
    do_start(8'h50, 8'h50, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy actual=%b required=1", busy); end
    checks++; if (D !== 8'hFF) begin failures++; $display("FAIL b2b_D_held_in_run actual=%h required=ff", D); end
    wait_done(edges, bc);
    checks++; if (edges !== W) begin failures++; $display("FAIL b2b_latency actual=%0d required=%0d", edges, W); end
    checks++; if (D !== 8'h00) begin failures++; $display("FAIL b2b_second_D actual=%h required=00", D); end
    checks++; if (B_out !== 1'b0) begin failures++; $display("FAIL b2b_second_B_out actual=%b required=0", B_out); end
    tick();
  endtask

  task automatic test_ignore_start();
    int edges, bc;
    do_start(8'hA5, 8'h25, 1'b0);
    tick();
    do_start(8'h01, 8'h02, 1'b0);
    A = 8'hFF;
    B = 8'hFF;
    B_in = 1'b1;
    wait_done(edges, bc);
    checks++; if (edges + 2 !== W) begin failures++; $display("FAIL ignore_latency actual=%0d required=%0d", edges + 2, W); end
    checks++; if (D !== 8'h80) begin failures++; $display("FAIL ignore_D actual=%h required=80", D); end
    checks++; if (B_out !== 1'b0) begin failures++; $display("FAIL ignore_B_out actual=%b required=0", B_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    int edges, bc;
    int seen_done;
    do_start(8'hC3, 8'h12, 1'b1);
    tick();
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy actual=%b required=0", busy); end
    checks++; if (D !== 8'h00) begin failures++; $display("FAIL rstmid_D actual=%h required=00", D); end
    checks++; if (B_out !== 1'b0) begin failures++; $display("FAIL rstmid_B_out actual=%b required=0", B_out); end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen_done++;
      tick();
    end
    checks++; if (seen_done !== 0) begin failures++; $display("FAIL rstmid_no_done actual=%0d required=0", seen_done); end
    do_start(8'h10, 8'h01, 1'b0);
    wait_done(edges, bc);
    checks++; if (D !== 8'h0F) begin failures++; $display("FAIL rstmid_after_D actual=%h required=0f", D); end
    checks++; if (B_out !== 1'b0) begin failures++; $display("FAIL rstmid_after_B_out actual=%b required=0", B_out); end
    tick();
  endtask

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  task automatic test_overflow();
    int edges, bc;
    do_start(8'h80, 8'h01, 1'b0);
    wait_done(edges, bc);
    checks++; if (D !== 8'h7F) begin failures++; $display("FAIL ovf1_D actual=%h required=7f", D); end
    checks++; if (V !== 1'b1) begin failures++; $display("FAIL ovf1_V actual=%b required=1", V); end
    tick();
    do_start(8'h05, 8'h03, 1'b0);
    wait_done(edges, bc);
    checks++; if (D !== 8'h02) begin failures++; $display("FAIL ovf2_D actual=%h required=02", D); end
    checks++; if (V !== 1'b0) begin failures++; $display("FAIL ovf2_V actual=%b required=0", V); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
